// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : video_timing_gen
//  Description : Video timing and test-pattern generator running on the
//                50 MHz system clock. A fractional accumulator produces the
//                pixel clock-enable; horizontal/vertical counters advance on
//                each strobe and drive registered sync, data-enable,
//                coordinates and RGB pattern data for the TMDS encoder.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_50m     in   1          system clock
//    rst         in   1          asynchronous active-high reset
//    en          in   1          run enable; low forces the generator idle
//    mode        in   2          0 bars, 1 gradient, 2 checkerboard, 3 solid
//    solid_rgb   in   3*COLOR_W  {R,G,B} colour for mode 3
//    pix_ce      out  1          one-cycle pixel-enable strobe
//    hsync       out  1          horizontal sync (HS_POL level when active)
//    vsync       out  1          vertical sync (VS_POL level when active)
//    de          out  1          data enable
//    x, y        out  16         active pixel coordinates (0 outside de)
//    rgb         out  3*COLOR_W  {R,G,B} pixel data (0 outside de)
//    frame_start out  1          marks pixel (0,0) of each frame
// ============================================================================
module video_timing_gen #(
    parameter int MAIN_FRE   = 50,
    parameter int VIDEO_RATE = 25,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int HS_POL     = 0,
    parameter int VS_POL     = 0,
    parameter int COLOR_W    = 8
) (
    input  logic                   clk_50m,
    input  logic                   rst,
    input  logic                   en,
    input  logic [1:0]             mode,
    input  logic [3*COLOR_W-1:0]   solid_rgb,
    output logic                   pix_ce,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   de,
    output logic [15:0]            x,
    output logic [15:0]            y,
    output logic [3*COLOR_W-1:0]   rgb,
    output logic                   frame_start
);

    localparam int C_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int C_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // Accumulator must hold acc + VIDEO_RATE, which never exceeds
    // MAIN_FRE - 1 + VIDEO_RATE.
    localparam int C_ACC_W   = $clog2(MAIN_FRE + VIDEO_RATE + 1);
    localparam int C_BAR_W   = (H_ACTIVE / 8 > 0) ? (H_ACTIVE / 8) : 1;

    localparam logic [C_ACC_W-1:0] C_RATE = C_ACC_W'(VIDEO_RATE);
    localparam logic [C_ACC_W-1:0] C_MAIN = C_ACC_W'(MAIN_FRE);

    localparam logic [15:0] C_H_LAST     = 16'(C_H_TOTAL - 1);
    localparam logic [15:0] C_V_LAST     = 16'(C_V_TOTAL - 1);
    localparam logic [15:0] C_H_ACT      = 16'(H_ACTIVE);
    localparam logic [15:0] C_V_ACT      = 16'(V_ACTIVE);
    localparam logic [15:0] C_HS_START   = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] C_HS_END     = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] C_VS_START   = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] C_VS_END     = 16'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic C_HS_ACT = (HS_POL != 0);
    localparam logic C_VS_ACT = (VS_POL != 0);

    logic [C_ACC_W-1:0]   r_acc;
    logic [15:0]          r_h_cnt;
    logic [15:0]          r_v_cnt;
    logic [1:0]           r_mode;

    logic [C_ACC_W-1:0]   w_acc_sum;
    logic                 w_origin;
    logic                 w_de;
    logic                 w_hs_act;
    logic                 w_vs_act;
    logic [1:0]           w_mode;
    logic [2:0]           w_bar;
    logic [3*COLOR_W-1:0] w_pix;

    assign w_acc_sum = r_acc + C_RATE;
    assign w_origin  = (r_h_cnt == 16'd0) && (r_v_cnt == 16'd0);
    assign w_de      = (r_h_cnt < C_H_ACT) && (r_v_cnt < C_V_ACT);
    assign w_hs_act  = (r_h_cnt >= C_HS_START) && (r_h_cnt < C_HS_END);
    assign w_vs_act  = (r_v_cnt >= C_VS_START) && (r_v_cnt < C_VS_END);

    // The origin pixel already uses the freshly sampled mode so that a new
    // pattern starts exactly at frame_start and never mid-frame.
    assign w_mode = w_origin ? mode : r_mode;

    // Bar index by threshold comparison; anything past bar 6 lands in bar 7,
    // which therefore absorbs the remainder of H_ACTIVE/8.
    always_comb begin
        w_bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (r_h_cnt >= 16'(k * C_BAR_W)) begin
                w_bar = 3'(k);
            end
        end
    end

    // Bar colours white, yellow, cyan, green, magenta, red, blue, black map
    // to R = ~idx[1], G = ~idx[2], B = ~idx[0].
    always_comb begin
        w_pix = '0;
        case (w_mode)
            2'd0: w_pix = {{COLOR_W{~w_bar[1]}}, {COLOR_W{~w_bar[2]}},
                           {COLOR_W{~w_bar[0]}}};
            2'd1: w_pix = {3{r_h_cnt[COLOR_W-1:0]}};
            2'd2: w_pix = (r_h_cnt[5] ^ r_v_cnt[5]) ? {3*COLOR_W{1'b1}}
                                                     : {3*COLOR_W{1'b0}};
            default: w_pix = solid_rgb;
        endcase
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
            r_mode      <= 2'd0;
            pix_ce      <= 1'b0;
            hsync       <= ~C_HS_ACT;
            vsync       <= ~C_VS_ACT;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            rgb         <= '0;
            frame_start <= 1'b0;
        end else if (!en) begin
            r_acc       <= '0;
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
            r_mode      <= 2'd0;
            pix_ce      <= 1'b0;
            hsync       <= ~C_HS_ACT;
            vsync       <= ~C_VS_ACT;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            rgb         <= '0;
            frame_start <= 1'b0;
        end else begin
            if (w_acc_sum >= C_MAIN) begin
                r_acc  <= w_acc_sum - C_MAIN;
                pix_ce <= 1'b1;
            end else begin
                r_acc  <= w_acc_sum;
                pix_ce <= 1'b0;
            end

            // Outputs capture the counter position of this strobe while the
            // counters move on, giving one strobe of latency.
            if (pix_ce) begin
                de          <= w_de;
                hsync       <= w_hs_act ? C_HS_ACT : ~C_HS_ACT;
                vsync       <= w_vs_act ? C_VS_ACT : ~C_VS_ACT;
                x           <= w_de ? r_h_cnt : 16'd0;
                y           <= w_de ? r_v_cnt : 16'd0;
                rgb         <= w_de ? w_pix : '0;
                frame_start <= w_origin;

                if (w_origin) begin
                    r_mode <= mode;
                end

                if (r_h_cnt == C_H_LAST) begin
                    r_h_cnt <= '0;
                    r_v_cnt <= (r_v_cnt == C_V_LAST) ? 16'd0 : r_v_cnt + 16'd1;
                end else begin
                    r_h_cnt <= r_h_cnt + 16'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_timing_gen
//  Description : Directed self-checking bench for video_timing_gen. Three
//                instances: A (640-wide, short frame, 25/50 rate), B (20/50
//                rate) and C (tiny timing, active-high hsync).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic [1:0]  a_mode;
    logic [23:0] a_solid;

    logic a_pix_ce, a_hsync, a_vsync, a_de, a_fs;
    logic [15:0] a_x, a_y;
    logic [23:0] a_rgb;
    logic b_pix_ce, b_hsync, b_vsync, b_de, b_fs;
    logic [15:0] b_x, b_y;
    logic [23:0] b_rgb;
    logic c_pix_ce, c_hsync, c_vsync, c_de, c_fs;
    logic [15:0] c_x, c_y;
    logic [23:0] c_rgb;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    video_timing_gen #(
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_dut_a (
        .clk_50m(clk), .rst(rst), .en(en), .mode(a_mode), .solid_rgb(a_solid),
        .pix_ce(a_pix_ce), .hsync(a_hsync), .vsync(a_vsync), .de(a_de),
        .x(a_x), .y(a_y), .rgb(a_rgb), .frame_start(a_fs)
    );

    video_timing_gen #(
        .VIDEO_RATE(20)
    ) u_dut_b (
        .clk_50m(clk), .rst(rst), .en(en), .mode(2'd0), .solid_rgb(24'h0),
        .pix_ce(b_pix_ce), .hsync(b_hsync), .vsync(b_vsync), .de(b_de),
        .x(b_x), .y(b_y), .rgb(b_rgb), .frame_start(b_fs)
    );

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1)
    ) u_dut_c (
        .clk_50m(clk), .rst(rst), .en(en), .mode(2'd0), .solid_rgb(24'h0),
        .pix_ce(c_pix_ce), .hsync(c_hsync), .vsync(c_vsync), .de(c_de),
        .x(c_x), .y(c_y), .rgb(c_rgb), .frame_start(c_fs)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the negedge where the next pixel is displayed.
    // which: 0 = instance A, 1 = instance C.
    task automatic next_pixel(input int which);
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while ((((which == 0) ? a_pix_ce : c_pix_ce) == 1'b0) && guard < 8);
        if (guard >= 8) check("strobe_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    int pa = 0;
    int de_cnt_a = 0;

    task automatic goto_a(input int n);
        while (pa < n) begin
            next_pixel(0);
            pa++;
            if (a_de) de_cnt_a++;
        end
    endtask

    // Called at the negedge where rst/en has just been released.
    task automatic restart_a(input logic [23:0] exp_rgb);
        @(negedge clk);
        check("a_pce_1st", a_pix_ce, 0);
        @(negedge clk);
        check("a_pce_2nd", a_pix_ce, 1);
        @(negedge clk);
        check("a_fs_origin", a_fs, 1);
        check("a_de_origin", a_de, 1);
        check("a_xy_origin", {a_x, a_y}, 0);
        check("a_rgb_origin", a_rgb, exp_rgb);
        pa = 0;
        de_cnt_a = 1;
    endtask

    initial begin
        int c_line0;
        int c_frame0;
        rst     = 1'b1;
        en      = 1'b1;
        a_mode  = 2'd0;
        a_solid = 24'h0;
        repeat (3) @(negedge clk);
        check("rst_pce", a_pix_ce, 0);
        check("rst_de", a_de, 0);
        check("rst_xy", {a_x, a_y}, 0);
        check("rst_rgb", a_rgb, 0);
        check("rst_fs", a_fs, 0);
        check("rst_hs_lowpol", a_hsync, 1);
        check("rst_vs_lowpol", a_vsync, 1);
        check("rst_hs_highpol", c_hsync, 0);
        rst = 1'b0;

        fork
            begin : a_frames
                restart_a(24'hFFFFFF);
                c_frame0 = cyc;
                goto_a(1);    check("a_fs_p1", a_fs, 0);
                goto_a(80);   check("a_bar1", a_rgb, 24'hFFFF00);
                              check("a_x80", a_x, 80);
                goto_a(639);  check("a_bar7", a_rgb, 24'h000000);
                              check("a_x639", a_x, 639);
                goto_a(640);  check("a_de_fp", a_de, 0);
                              check("a_x_blank", a_x, 0);
                goto_a(655);  check("a_hs_655", a_hsync, 1);
                goto_a(656);  check("a_hs_656", a_hsync, 0);
                              c_line0 = cyc;
                goto_a(751);  check("a_hs_751", a_hsync, 0);
                goto_a(752);  check("a_hs_752", a_hsync, 1);
                goto_a(801);  check("a_xy_line1", {a_x, a_y}, {16'd1, 16'd1});
                goto_a(1456); check("a_line_clk", cyc - c_line0, 1600);
                goto_a(1700);
                a_mode  = 2'd3;
                a_solid = 24'h123456;
                goto_a(1760); check("a_bar2_hold", a_rgb, 24'h00FFFF);
                goto_a(2800); check("a_bar5_hold", a_rgb, 24'hFF0000);
                goto_a(3999); check("a_vs_3999", a_vsync, 1);
                goto_a(4000); check("a_vs_4000", a_vsync, 0);
                              check("a_de_vfp", a_de, 0);
                goto_a(4799); check("a_vs_4799", a_vsync, 0);
                goto_a(4800); check("a_vs_4800", a_vsync, 1);
                goto_a(5599); check("a_de_count", de_cnt_a, 2560);
                goto_a(5600); check("a_fs_frame2", a_fs, 1);
                              check("a_solid", a_rgb, 24'h123456);
                              check("a_frame_clk", cyc - c_frame0, 11200);
            end
            begin : b_rate
                logic [0:4] pat;
                int cnt;
                pat = 5'b00101;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    check("b_pce_pat", b_pix_ce, {31'd0, pat[i % 5]});
                end
                cnt = 0;
                for (int i = 0; i < 1000; i++) begin
                    @(negedge clk);
                    if (b_pix_ce) cnt++;
                end
                check("b_pce_count", cnt, 400);
            end
            begin : c_small
                int pc;
                int de_c;
                @(negedge clk);
                @(negedge clk);
                @(negedge clk);
                check("c_fs_origin", c_fs, 1);
                check("c_hs_origin", c_hsync, 0);
                pc = 0;
                de_c = c_de ? 1 : 0;
                while (pc < 84) begin
                    next_pixel(1);
                    pc++;
                    if (pc < 84 && c_de) de_c++;
                    case (pc)
                        8:  check("c_hs_8", c_hsync, 0);
                        9:  check("c_hs_9", c_hsync, 1);
                        10: check("c_hs_10", c_hsync, 1);
                        11: check("c_hs_11", c_hsync, 0);
                        59: check("c_vs_v4", c_vsync, 1);
                        60: check("c_vs_v5h0", c_vsync, 0);
                        71: check("c_vs_v5h11", c_vsync, 0);
                        72: check("c_vs_v6", c_vsync, 1);
                        default: ;
                    endcase
                end
                check("c_fs_frame2", c_fs, 1);
                check("c_de_count", de_c, 32);
            end
        join

        // Asynchronous reset in the middle of a frame (line 2 of frame 2).
        goto_a(5600 + 2 * 800 + 10);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_pce", a_pix_ce, 0);
        check("mrst_de", a_de, 0);
        check("mrst_xy", {a_x, a_y}, 0);
        check("mrst_rgb", a_rgb, 0);
        check("mrst_sync", {a_hsync, a_vsync}, 2'b11);
        check("mrst_fs", a_fs, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        restart_a(24'h123456);

        // Drop en for 10 clk mid-line.
        goto_a(800 + 300);
        en = 1'b0;
        @(negedge clk);
        check("en_de", a_de, 0);
        check("en_pce", a_pix_ce, 0);
        check("en_hs", a_hsync, 1);
        check("en_xy", {a_x, a_y}, 0);
        repeat (9) @(negedge clk);
        en = 1'b1;
        restart_a(24'h123456);
        goto_a(1);
        check("en_x1", a_x, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
